i2c_slave: RTL and testbench
============================

# i2c_slave

Register-mapped I2C target that answers the team's I2C master on the same two-wire bus. It decodes START, repeated START and STOP, matches a 7-bit device address, and accepts a register-pointer byte followed by write data or streams read data. It holds a local byte-wide register file that the application reads and writes through a side port. It serves as a BME280 stand-in for bench and loopback builds and as a general target block.

## Interface

**Parameters**

- `SLAVE_ADDRESS` = 7'h76: device address this block answers to.
- `REG_ADDR_W` = 4: register file holds 2^REG_ADDR_W bytes.
- `SYNC_STAGES` = 2: synchronizer depth on `scl` and `sda_in`; must be at least 2.

**Ports**

- `clk` in 1: system clock, the only clock in the block.
- `rst` in 1: reset, synchronous, active-low.
- `scl` in 1: bus clock from the master, sampled on `clk`.
- `sda_in` in 1: bus data, sampled on `clk`.
- `sda_out` in 0-direction: out 1; value driven when `tristate`=0. It is only ever driven 0.
- `tristate` out 1: 1 releases SDA, 0 drives `sda_out`.
- `ext_wr_en` in 1: application write strobe.
- `ext_wr_addr` in REG_ADDR_W: application write address.
- `ext_wr_data` in 8: application write data.
- `ext_rd_addr` in REG_ADDR_W: application read address.
- `ext_rd_data` out 8: registered read of `reg[ext_rd_addr]`; 1 clk latency.
- `wr_valid` out 1: 1-clk pulse when the bus master writes a register.
- `wr_addr` out REG_ADDR_W: register index of that bus write.
- `wr_data` out 8: data of that bus write.
- `busy` out 1: high from the addressed START until STOP, or until the transaction is abandoned.

## Operation

**Bus sampling and events**
- `scl` and `sda_in` pass through SYNC_STAGES flops, then one history flop feeds edge detection.
- Derived events: scl_rise, scl_fall, START (SDA falls while SCL high), STOP (SDA rises while SCL high).

**States**
- IDLE, ADDR, ADDR_ACK, REG_PTR, REG_PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.

**Bit handling**
- Bits are sampled MSB first on scl_rise and counted with a 3-bit counter.
- The block's own SDA changes only on scl_fall.

**Transitions**
- START from any state: go to ADDR, clear the bit counter, release SDA. This covers repeated START.
- STOP from any state: go to IDLE, release SDA, drop `busy`.
- ADDR, after 8 bits:
  - Address matches `SLAVE_ADDRESS`: go to ADDR_ACK, latch R/W, raise `busy`.
  - Mismatch: go to WAIT_STOP and stay released.
- ADDR_ACK: drive 0 from the scl_fall after bit 8 through the next scl_fall. Then:
  - R/W=0: go to REG_PTR.
  - R/W=1: go to RD_DATA and preload the shifter with `reg[ptr]`.
- REG_PTR: after 8 bits, ptr ← byte[REG_ADDR_W-1:0]; the upper bits are ignored. ACK in REG_PTR_ACK, then go to WR_DATA.
- WR_DATA: after 8 bits:
  - `reg[ptr]` ← byte.
  - Pulse `wr_valid` with the pre-increment ptr.
  - ptr ← ptr+1, wrapping modulo 2^REG_ADDR_W.
  - ACK in WR_ACK, then return to WR_DATA.
- RD_DATA: drive the shifter MSB; shift on each scl_fall; drive 0 for data bit 0 and release for data bit 1. After 8 bits, release SDA and go to RD_ACK.
- RD_ACK: sample the master's bit on scl_rise.
  - 0 (ACK): ptr+1, load the next byte, go to RD_DATA.
  - 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: SDA released; leaves only on START or STOP.

**Register file and ptr**
- ptr persists across transactions, so a write-pointer then repeated START then read sequence reads from the set pointer.
- On the same clk, a bus write and an `ext_wr_en` to the same index: the bus write wins. Different indices: both complete.

**Reset**
- Mid-transaction reset aborts to IDLE.
- Reset clears the register file to 0 and ptr to 0.

## Timing

**Reset values**
- `tristate`=1, `sda_out`=1, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `ext_rd_data`=0.

**Latencies**
- Bus event detection: SYNC_STAGES+1 clk after the pin change.
- SDA drive update: 1 clk after a detected scl_fall.
- `wr_valid`: asserts 1 clk after the scl_rise sampling bit 0 of a data byte.

**Bus timing requirement**
- SCL high and low phases must each last at least SYNC_STAGES+3 clk.
- SDA must be stable around scl_rise for at least SYNC_STAGES+1 clk.
- The master's clk/2 SCL mode does not meet this; loopback builds run the master at a divided rate.

## Structure

- Shared package `i2c_pkg`:
  - State enum (shared naming with the master's states).
  - ACK=1'b0 and NACK=1'b1 constants.
  - BME280 default address 7'h76.
- Sub-module `i2c_bus_sync`: synchronizer plus scl_rise, scl_fall, START and STOP detection. The FSM, shifter, ptr and register file stay in `i2c_slave`.

## Test plan

- Write: START, 0xEC, 0x03, 0xA5, 0x5A, STOP → ACK on all four bytes; `wr_valid` pulses twice with (3, 0xA5) then (4, 0x5A); `ext_rd_data` at address 4 reads 0x5A.
- Read: START, 0xEC, 0x03, repeated START, 0xED; master ACKs then NACKs → bytes 0xA5 then 0x5A are driven; SDA released after the NACK; `busy` drops at STOP.
- Address mismatch: START, 0xEE, … → no ACK (SDA released on the 9th clock); `busy` stays 0; no `wr_valid`.
- Wrap: set ptr to 0x0F, write 0x11 and 0x22 → `wr_addr` sequence is 15 then 0.
- Collision: bus write to reg 2 and `ext_wr_en` to reg 2 on the same clk → reg 2 holds the bus data.
- Abort: assert `rst` low mid-read while SDA is driven 0 → next clk `tristate`=1; the bus recovers on the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state names, ACK/NACK bit values and the
// default BME280 device address.
package i2c_pkg;

    localparam logic [6:0] BME280_ADDR = 7'h76;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG_PTR,
        REG_PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronizes scl/sda_in into the clk domain and decodes
// SCL edges plus START/STOP conditions.
// Ports:
//   clk, rst      system clock, synchronous active-low reset
//   scl, sda_in   raw bus pins
//   sda_s         synchronized SDA level
//   scl_rise_c    SCL rising edge (combinational, one clk wide)
//   scl_fall_c    SCL falling edge
//   start_c       SDA fell while SCL high
//   stop_c        SDA rose while SCL high
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;

    // Synchronizer chain plus one history flop; idle bus level is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise_c = scl_s & ~scl_hist;
    assign scl_fall_c = ~scl_s & scl_hist;
    // SCL must be high on both samples so an SCL edge never reads as START/STOP.
    assign start_c    = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_c     = scl_s & scl_hist & ~sda_hist & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Register-mapped I2C target with a byte-wide local register file.
// Ports:
//   clk, rst                 system clock, synchronous active-low reset
//   scl, sda_in              bus pins (sampled on clk)
//   sda_out, tristate        open-drain SDA drive (tristate=1 releases)
//   ext_wr_en/addr/data      application write port
//   ext_rd_addr/ext_rd_data  application read port, 1 clk latency
//   wr_valid/wr_addr/wr_data pulse reporting each bus-master register write
//   busy                     addressed transaction in progress
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDRESS = BME280_ADDR,
    parameter int unsigned REG_ADDR_W    = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  tristate,
    input  logic                  ext_wr_en,
    input  logic [REG_ADDR_W-1:0] ext_wr_addr,
    input  logic [7:0]            ext_wr_data,
    input  logic [REG_ADDR_W-1:0] ext_rd_addr,
    output logic [7:0]            ext_rd_data,
    output logic                  wr_valid,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_s      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    i2c_state_t            state_q, state_n;
    logic [2:0]            bit_cnt_q, bit_cnt_n;
    logic [7:0]            shift_q, shift_n;
    logic [REG_ADDR_W-1:0] ptr_q, ptr_n;
    logic                  rw_q, rw_n;
    logic                  tristate_n, busy_n, wr_valid_n;
    logic [REG_ADDR_W-1:0] wr_addr_n;
    logic [7:0]            wr_data_n;
    logic                  bus_we_c;
    logic [7:0]            rx_byte_c;
    logic                  byte_done_c;
    logic [REG_ADDR_W-1:0] ptr_inc_c;
    logic [7:0]            regs [NUM_REGS];

    assign rx_byte_c   = {shift_q[6:0], sda_s};
    assign byte_done_c = scl_rise_c && (bit_cnt_q == 3'd7);
    assign ptr_inc_c   = ptr_q + REG_ADDR_W'(1);

    // Next-state and datapath decisions.
    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q;
        shift_n    = shift_q;
        ptr_n      = ptr_q;
        rw_n       = rw_q;
        tristate_n = tristate;
        busy_n     = busy;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        bus_we_c   = 1'b0;

        if (start_c) begin
            state_n    = ADDR;
            bit_cnt_n  = 3'd0;
            tristate_n = 1'b1;
        end else if (stop_c) begin
            state_n    = IDLE;
            tristate_n = 1'b1;
            busy_n     = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG_PTR, WR_DATA: begin
                    if (scl_rise_c) begin
                        shift_n   = rx_byte_c;
                        bit_cnt_n = bit_cnt_q + 3'd1;
                    end
                    if (byte_done_c) begin
                        if (state_q == ADDR) begin
                            if (rx_byte_c[7:1] == SLAVE_ADDRESS) begin
                                state_n = ADDR_ACK;
                                rw_n    = rx_byte_c[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end else if (state_q == REG_PTR) begin
                            ptr_n   = rx_byte_c[REG_ADDR_W-1:0];
                            state_n = REG_PTR_ACK;
                        end else begin
                            bus_we_c   = 1'b1;
                            wr_valid_n = 1'b1;
                            wr_addr_n  = ptr_q;
                            wr_data_n  = rx_byte_c;
                            ptr_n      = ptr_inc_c;
                            state_n    = WR_ACK;
                        end
                    end
                end
                // First fall after the byte starts the ACK, the second ends it.
                ADDR_ACK, REG_PTR_ACK, WR_ACK: begin
                    if (scl_fall_c) begin
                        if (tristate) begin
                            tristate_n = ACK;
                        end else begin
                            tristate_n = 1'b1;
                            bit_cnt_n  = 3'd0;
                            if (state_q != ADDR_ACK) begin
                                state_n = WR_DATA;
                            end else if (!rw_q) begin
                                state_n = REG_PTR;
                            end else begin
                                state_n    = RD_DATA;
                                shift_n    = regs[ptr_q];
                                tristate_n = regs[ptr_q][7];
                            end
                        end
                    end
                end
                // Bit count advances per fall; the 8th fall hands SDA back.
                RD_DATA: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == 3'd7) begin
                            tristate_n = 1'b1;
                            bit_cnt_n  = 3'd0;
                            state_n    = RD_ACK;
                        end else begin
                            shift_n    = {shift_q[6:0], 1'b0};
                            bit_cnt_n  = bit_cnt_q + 3'd1;
                            tristate_n = shift_q[6];
                        end
                    end
                end
                // Any fall seen here follows an ACK, since NACK leaves the state.
                RD_ACK: begin
                    if (scl_rise_c) begin
                        if (sda_s == NACK) begin
                            state_n = WAIT_STOP;
                        end else begin
                            ptr_n   = ptr_inc_c;
                            shift_n = regs[ptr_inc_c];
                        end
                    end else if (scl_fall_c) begin
                        state_n    = RD_DATA;
                        bit_cnt_n  = 3'd0;
                        tristate_n = shift_q[7];
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and output registers; sda_out is 0 whenever SDA is driven.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            tristate  <= 1'b1;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'd0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shift_q   <= shift_n;
            ptr_q     <= ptr_n;
            rw_q      <= rw_n;
            tristate  <= tristate_n;
            sda_out   <= tristate_n;
            busy      <= busy_n;
            wr_valid  <= wr_valid_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
        end
    end

    // Register file; a bus write beats an application write to the same index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
            ext_rd_data <= 8'd0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (bus_we_c && (ptr_q == REG_ADDR_W'(i))) begin
                    regs[i] <= rx_byte_c;
                end else if (ext_wr_en && (ext_wr_addr == REG_ADDR_W'(i))) begin
                    regs[i] <= ext_wr_data;
                end
            end
            ext_rd_data <= regs[ext_rd_addr];
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master, a register-file reference
// model and a wr_valid scoreboard.
module tb_i2c_slave;

    localparam int         HALF  = 10;
    localparam logic [7:0] DEV_W = 8'hEC;
    localparam logic [7:0] DEV_R = 8'hED;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m, sda_line;
    logic       sda_out, tristate;
    logic       ext_wr_en;
    logic [3:0] ext_wr_addr;
    logic [7:0] ext_wr_data;
    logic [3:0] ext_rd_addr;
    logic [7:0] ext_rd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_regs [16];
    int         model_ptr;
    wr_exp_t    exp_q [$];
    logic [7:0] buf_data [8];
    logic       ack, hit;
    logic [7:0] rd;

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and target.
    assign sda_line = sda_m & (tristate | sda_out);

    i2c_slave dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (scl_m),
        .sda_in      (sda_line),
        .sda_out     (sda_out),
        .tristate    (tristate),
        .ext_wr_en   (ext_wr_en),
        .ext_wr_addr (ext_wr_addr),
        .ext_wr_data (ext_wr_data),
        .ext_rd_addr (ext_rd_addr),
        .ext_rd_data (ext_rd_data),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic r);
        wait_clks(HALF/2); sda_m = b;
        wait_clks(HALF/2); scl_m = 1'b1;
        wait_clks(HALF/2); r = sda_line;
        wait_clks(HALF/2); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i], r);
        send_bit(1'b1, a);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            d[i] = r;
        end
        send_bit(master_ack, r);
    endtask

    task automatic bus_start();
        wait_clks(HALF/2); sda_m = 1'b1;
        wait_clks(HALF/2); scl_m = 1'b1;
        wait_clks(HALF/2); sda_m = 1'b0;
        wait_clks(HALF/2); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clks(HALF/2); sda_m = 1'b0;
        wait_clks(HALF/2); scl_m = 1'b1;
        wait_clks(HALF/2); sda_m = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic set_pointer(input logic [7:0] ptr8);
        logic a;
        bus_start();
        write_byte(DEV_W, a);
        check("addr_w_ack", a, 1'b0);
        write_byte(ptr8, a);
        check("ptr_ack", a, 1'b0);
        model_ptr = ptr8 % 16;
    endtask

    // Bus write of buf_data[0..n-1] starting at ptr8.
    task automatic txn_write(input logic [7:0] ptr8, input int n);
        logic a;
        wr_exp_t e;
        set_pointer(ptr8);
        for (int i = 0; i < n; i++) begin
            e.addr = 4'(model_ptr);
            e.data = buf_data[i];
            exp_q.push_back(e);
            model_regs[model_ptr] = buf_data[i];
            model_ptr = (model_ptr + 1) % 16;
            write_byte(buf_data[i], a);
            check("data_ack", a, 1'b0);
        end
        bus_stop();
        check("busy_after_write", busy, 1'b0);
    endtask

    // Read n bytes, optionally setting the pointer first via repeated START.
    task automatic txn_read(input logic set_ptr, input logic [7:0] ptr8, input int n);
        logic a;
        logic [7:0] d;
        if (set_ptr) set_pointer(ptr8);
        bus_start();
        write_byte(DEV_R, a);
        check("addr_r_ack", a, 1'b0);
        check("busy_in_read", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1), d);
            check("rd_data", d, model_regs[model_ptr]);
            if (i != n - 1) model_ptr = (model_ptr + 1) % 16;
        end
        check("released_after_nack", tristate, 1'b1);
        bus_stop();
        check("busy_after_read", busy, 1'b0);
    endtask

    task automatic txn_mismatch(input logic [6:0] a7, input logic rw);
        logic a;
        bus_start();
        write_byte({a7, rw}, a);
        check("mismatch_no_ack", a, 1'b1);
        check("mismatch_busy", busy, 1'b0);
        write_byte(8'($urandom), a);
        check("mismatch_no_ack2", a, 1'b1);
        bus_stop();
    endtask

    task automatic ext_write(input int a, input logic [7:0] d);
        ext_wr_en = 1'b1; ext_wr_addr = 4'(a); ext_wr_data = d;
        wait_clks(1);
        ext_wr_en = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic ext_read_check(input int a);
        ext_rd_addr = 4'(a);
        wait_clks(1);
        check("ext_rd_data", ext_rd_data, model_regs[a]);
    endtask

    // Scoreboard monitor: every wr_valid pulse must match the next expected write.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && wr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wr_valid: got addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time budget exceeded, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        ext_wr_en = 1'b0; ext_wr_addr = 4'd0; ext_wr_data = 8'd0; ext_rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
        model_ptr = 0;
        wait_clks(5);
        check("rst_tristate", tristate, 1'b1);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'd0);
        check("rst_ext_rd_data", ext_rd_data, 8'd0);
        rst = 1'b1;
        wait_clks(5);

        buf_data[0] = 8'hA5; buf_data[1] = 8'h5A;
        txn_write(8'h03, 2);
        ext_read_check(4);
        check("ext_rd_4_const", ext_rd_data, 8'h5A);

        txn_read(1'b1, 8'h03, 2);

        txn_mismatch(7'h77, 1'b0);

        buf_data[0] = 8'h11; buf_data[1] = 8'h22;
        txn_write(8'h0F, 2);

        // Collision: ext write to reg 2 held until the bus write to reg 2 lands.
        set_pointer(8'h02);
        begin
            wr_exp_t e;
            e.addr = 4'd2; e.data = 8'hC3;
            exp_q.push_back(e);
        end
        model_regs[2] = 8'hC3;
        model_ptr = 3;
        hit = 1'b0;
        fork
            write_byte(8'hC3, ack);
            begin
                ext_wr_en = 1'b1; ext_wr_addr = 4'd2; ext_wr_data = 8'h77;
                for (int i = 0; i < 2000 && wr_valid !== 1'b1; i++) @(negedge clk);
                hit = wr_valid;
                ext_wr_en = 1'b0;
            end
        join
        check("collision_wr_seen", hit, 1'b1);
        check("collision_ack", ack, 1'b0);
        bus_stop();
        ext_read_check(2);

        // Abort: reset while the target drives a 0 data bit.
        buf_data[0] = 8'h3C;
        txn_write(8'h05, 1);
        set_pointer(8'h05);
        bus_start();
        write_byte(DEV_R, ack);
        check("abort_addr_ack", ack, 1'b0);
        wait_clks(HALF/2);
        check("abort_driving", tristate, 1'b0);
        rst = 1'b0;
        wait_clks(1);
        check("abort_tristate", tristate, 1'b1);
        check("abort_busy", busy, 1'b0);
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clks(4);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'd0;
        model_ptr = 0;
        wait_clks(10);
        txn_read(1'b0, 8'h00, 1);
        buf_data[0] = 8'h96;
        txn_write(8'h07, 1);
        ext_read_check(7);

        for (int t = 0; t < 24; t++) begin
            int n;
            logic [6:0] a7;
            case ($urandom_range(0, 4))
                0: begin
                    n = int'($urandom_range(1, 3));
                    for (int i = 0; i < n; i++) buf_data[i] = 8'($urandom);
                    txn_write(8'($urandom), n);
                end
                1: txn_read(1'b1, 8'($urandom), int'($urandom_range(1, 3)));
                2: txn_read(1'b0, 8'h00, int'($urandom_range(1, 2)));
                3: begin
                    n = int'($urandom_range(0, 15));
                    ext_write(n, 8'($urandom));
                    ext_read_check(int'($urandom_range(0, 15)));
                    ext_read_check(n);
                end
                default: begin
                    a7 = 7'($urandom);
                    if (a7 == 7'h76) a7 = 7'h77;
                    txn_mismatch(a7, 1'($urandom));
                end
            endcase
        end

        wait_clks(20);
        check("wr_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
